// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, FSM state type and address-field helpers for the data cache
package cache_pkg;

    localparam int SETS  = 64;
    localparam int IW    = $clog2(SETS);
    localparam int TAG_W = 11;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int iw);
        return (addr >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    // Tag stops at bit 18: the SRAM only spans 512 KB, so higher bits never alias.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int iw);
        logic [31:0] low;
        low = {13'd0, addr[18:0]};
        return low >> (2 + iw);
    endfunction

endpackage

// File: rtl/cache_storage.sv
// rtl/cache_storage.sv - two-way valid/tag/data/lru arrays with async read and sync write
module cache_storage #(
    parameter int SETS  = 64,
    parameter int TAG_W = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(SETS)-1:0]  index,
    output logic [1:0]               valid,
    output logic [TAG_W-1:0]         tag0,
    output logic [TAG_W-1:0]         tag1,
    output logic [31:0]              data0,
    output logic [31:0]              data1,
    output logic                     lru,
    input  logic                     fill_en,
    input  logic                     fill_way,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic [31:0]              fill_data,
    input  logic                     upd_en,
    input  logic                     upd_way,
    input  logic [31:0]              upd_data,
    input  logic                     lru_en,
    input  logic                     lru_val
);
    import cache_pkg::*;

    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [31:0]      data_q [2][SETS];
    logic [SETS-1:0]  valid0_q;
    logic [SETS-1:0]  valid1_q;
    logic [SETS-1:0]  lru_q;

    assign valid = {valid1_q[index], valid0_q[index]};
    assign tag0  = tag_q[0][index];
    assign tag1  = tag_q[1][index];
    assign data0 = data_q[0][index];
    assign data1 = data_q[1][index];
    assign lru   = lru_q[index];

    // Tag and data contents are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_way][index]  <= fill_tag;
            data_q[fill_way][index] <= fill_data;
        end else if (upd_en) begin
            data_q[upd_way][index] <= upd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (fill_en) begin
                if (fill_way) valid1_q[index] <= 1'b1;
                else          valid0_q[index] <= 1'b1;
            end
            if (lru_en) lru_q[index] <= lru_val;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way write-through no-write-allocate cache; CACHE_STATS_EN adds hit/miss counters
module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    import cache_pkg::*;

    localparam int IW = $clog2(SETS);

    state_t           state_q;
    logic             sram_read_q;
    logic             sram_write_q;
    logic [IW-1:0]    req_index;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       valid;
    logic [TAG_W-1:0] tag0;
    logic [TAG_W-1:0] tag1;
    logic [31:0]      data0;
    logic [31:0]      data1;
    logic             lru;
    logic             hit0;
    logic             hit1;
    logic             hit;
    logic             hit_way;
    logic             victim;
    logic             is_store;
    logic             is_load;
    logic             load_hit_now;
    logic             fill_done;
    logic             write_done;

    assign req_index = IW'(addr_index(address, IW));
    assign req_tag   = TAG_W'(addr_tag(address, IW));

    assign hit0    = valid[0] && (tag0 == req_tag);
    assign hit1    = valid[1] && (tag1 == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;
    assign victim  = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);

    // A store wins when both enables are raised together.
    assign is_store     = MEM_W_EN;
    assign is_load      = MEM_R_EN && !MEM_W_EN;
    assign load_hit_now = (state_q == IDLE) && is_load && hit;
    assign fill_done    = (state_q == READ) && sram_ready;
    assign write_done   = (state_q == WRITE) && sram_ready;

    assign sram_address = address;
    assign sram_wdata   = wdata;
    assign sram_read    = sram_read_q;
    assign sram_write   = sram_write_q;

    cache_storage #(.SETS(SETS), .TAG_W(TAG_W)) u_storage (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index),
        .valid     (valid),
        .tag0      (tag0),
        .tag1      (tag1),
        .data0     (data0),
        .data1     (data1),
        .lru       (lru),
        .fill_en   (fill_done),
        .fill_way  (victim),
        .fill_tag  (req_tag),
        .fill_data (sram_rdata),
        .upd_en    (write_done && hit),
        .upd_way   (hit_way),
        .upd_data  (wdata),
        .lru_en    (load_hit_now || fill_done || (write_done && hit)),
        .lru_val   (fill_done ? !victim : !hit_way)
    );

    always_comb begin
        ready = 1'b1;
        rdata = '0;
        unique case (state_q)
            IDLE: begin
                ready = !(is_store || (is_load && !hit));
                if (load_hit_now) rdata = hit0 ? data0 : data1;
            end
            READ: begin
                ready = sram_ready;
                if (sram_ready) rdata = sram_rdata;
            end
            WRITE:   ready = sram_ready;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_store) begin
                        state_q      <= WRITE;
                        sram_write_q <= 1'b1;
                    end else if (is_load && !hit) begin
                        state_q     <= READ;
                        sram_read_q <= 1'b1;
                    end
                end
                READ: begin
                    if (sram_ready) begin
                        state_q     <= IDLE;
                        sram_read_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        state_q      <= IDLE;
                        sram_write_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (load_hit_now) hit_count  <= hit_count + 32'd1;
            if (fill_done)    miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized bench for cache_controller against an LRU-queue cache model
module tb_cache_controller;

    localparam int SETS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // External SRAM contents and the bench's own view of what memory should hold.
    logic [31:0] sram_mem [int];
    logic [31:0] ref_mem  [int];
    int          lines [SETS][$];
    int          model_hits   = 0;
    int          model_misses = 0;
    int          wait_cnt     = 0;
    bit          hold_sram    = 1'b0;
    int          rd_pulses    = 0;

    function automatic logic [31:0] default_word(input int key);
        return (32'(key) * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    function automatic bit model_resident(input int key);
        int s = key % SETS;
        for (int i = 0; i < lines[s].size(); i++)
            if (lines[s][i] == key) return 1'b1;
        return 1'b0;
    endfunction

    // Most recently used line sits at the back; a full set evicts the front.
    function automatic void model_access(input int key);
        int s = key % SETS;
        for (int i = 0; i < lines[s].size(); i++) begin
            if (lines[s][i] == key) begin
                lines[s].delete(i);
                break;
            end
        end
        if (lines[s].size() == 2) void'(lines[s].pop_front());
        lines[s].push_back(key);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) lines[s].delete();
        model_hits   = 0;
        model_misses = 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sram_ready = 1'b0;
            wait_cnt   = 0;
        end else if (sram_ready) begin
            sram_ready = 1'b0;
        end else if ((sram_read || sram_write) && !hold_sram) begin
            if (wait_cnt == 0) wait_cnt = $urandom_range(1, 3);
            wait_cnt--;
            if (wait_cnt == 0) begin
                int k;
                k = int'(sram_address[18:2]);
                sram_ready = 1'b1;
                if (sram_write) begin
                    sram_mem[k] = sram_wdata;
                end else begin
                    sram_rdata = sram_mem.exists(k) ? sram_mem[k] : default_word(k);
                    rd_pulses++;
                end
            end
        end
    end

    // want: 0 = must miss, 1 = must hit, 2 = whatever the model says
    task automatic do_load(input logic [31:0] a, input int want);
        int          key = int'(a[18:2]);
        bit          res = model_resident(key);
        bit          exp_hit;
        logic [31:0] exp_d;
        int          n;
        bit          got;
        exp_hit = (want == 2) ? res : (want == 1);
        exp_d   = ref_mem.exists(key) ? ref_mem[key] : default_word(key);
        address  = a;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        #1;
        expect_eq("ld_ready_now", {31'd0, ready}, {31'd0, exp_hit});
        if (exp_hit) begin
            expect_eq("ld_hit_data", rdata, exp_d);
            expect_eq("ld_hit_no_sram", {31'd0, sram_read}, 32'd0);
        end else begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                #1;
                n++;
                if (n == 1) begin
                    expect_eq("ld_sram_read", {31'd0, sram_read}, 32'd1);
                    expect_eq("ld_sram_addr", sram_address, a);
                end
                expect_eq("ld_wait_ready", {31'd0, ready}, {31'd0, sram_ready});
                got = ready;
            end
            expect_eq("ld_miss_done", {31'd0, got}, 32'd1);
            expect_eq("ld_miss_data", rdata, exp_d);
        end
        if (res) model_hits++;
        else     model_misses++;
        model_access(key);
        @(negedge clk);
        MEM_R_EN = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
        int key = int'(a[18:2]);
        int n;
        bit got;
        address  = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        MEM_R_EN = both;
        #1;
        expect_eq("st_ready_now", {31'd0, ready}, 32'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 1) begin
                expect_eq("st_sram_write", {31'd0, sram_write}, 32'd1);
                expect_eq("st_no_read", {31'd0, sram_read}, 32'd0);
                expect_eq("st_sram_wdata", sram_wdata, d);
            end
            expect_eq("st_wait_ready", {31'd0, ready}, {31'd0, sram_ready});
            got = ready;
        end
        expect_eq("st_done", {31'd0, got}, 32'd1);
        ref_mem[key] = d;
        if (model_resident(key)) model_access(key);
        @(negedge clk);
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          rd0;
        rst        = 1'b1;
        address    = '0;
        wdata      = '0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        sram_rdata = '0;
        sram_ready = 1'b0;
        sram_mem[32'h400 >> 2] = 32'hDEADBEEF;
        ref_mem[32'h400 >> 2]  = 32'hDEADBEEF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        expect_eq("rst_rdata", rdata, 32'd0);
        expect_eq("rst_ready", {31'd0, ready}, 32'd1);
        expect_eq("rst_sram_read", {31'd0, sram_read}, 32'd0);
        expect_eq("rst_sram_write", {31'd0, sram_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_load(32'h400, 0);
        do_load(32'h400, 1);
        do_store(32'h400, 32'h12345678, 1'b0);
        do_load(32'h400, 1);

        rd0 = rd_pulses;
        do_store(32'h800, 32'hCAFEF00D, 1'b0);
        do_load(32'h800, 0);
        expect_eq("no_alloc_one_read", 32'(rd_pulses - rd0), 32'd1);

        do_load(32'h000, 0);
        do_load(32'h100, 0);
        do_load(32'h000, 1);
        do_load(32'h200, 0);
        do_load(32'h000, 1);
        do_load(32'h100, 0);

        for (int i = 0; i < 150; i++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 2)) << 2)
              | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 20);
            if ($urandom_range(0, 9) < 3) do_store(a, $urandom, $urandom_range(0, 4) == 0);
            else                          do_load(a, 2);
        end

        hold_sram = 1'b1;
        address   = 32'h600;
        MEM_R_EN  = 1'b1;
        #1;
        expect_eq("rst_mid_req_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        expect_eq("rst_mid_pending", {31'd0, sram_read}, 32'd1);
        rst = 1'b1;
        #1;
        expect_eq("rst_mid_read_drop", {31'd0, sram_read}, 32'd0);
        expect_eq("rst_mid_write_low", {31'd0, sram_write}, 32'd0);
        @(negedge clk);
        MEM_R_EN  = 1'b0;
        rst       = 1'b0;
        hold_sram = 1'b0;
        model_reset();
        @(negedge clk);
        do_load(32'h400, 0);
        do_load(32'h400, 1);
        do_load(32'h400, 1);
        do_load(32'h400, 1);
        do_load(32'h004, 0);
`ifdef CACHE_STATS_EN
        expect_eq("hit_count", hit_count, 32'd3);
        expect_eq("miss_count", miss_count, 32'd2);
        expect_eq("hit_count_model", hit_count, 32'(model_hits));
        expect_eq("miss_count_model", miss_count, 32'(model_misses));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
